// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller and the IF stage.
// Holds the controller state encoding and the common 32-bit fetch address type.
package hazard_pkg;

    localparam int REG_W_DEF = 4;
    localparam int ADDR_W    = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used for the stall and flush statistics.
// Once it reaches all-ones it sticks there instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end pipeline control: freezes IF and IF/ID on data hazards and memory
// waits, and flushes IF/ID on taken branches resolved in EXE.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int FLUSH_EXTRA = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwardEn,
    input  logic             useSrc1,
    input  logic             twoSrc,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic [REG_W-1:0] exeDest,
    input  logic             exeWbEn,
    input  logic             exeMemRen,
    input  logic [REG_W-1:0] memDest,
    input  logic             memWbEn,
    input  logic             memBusy,
    input  logic             exeBranch,
    input  addr_t            exeBranchAddr,
    output logic             freeze,
    output logic             flush,
    output logic             branchTaken,
    output addr_t            branchAddr,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output state_t           dbgState
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_EXTRA);

    state_t     state, state_nx;
    logic [2:0] fcnt, fcnt_nx;
    logic       hit1_exe, hit2_exe, hit1_mem, hit2_mem;
    logic       hazard;

    assign hit1_exe = useSrc1 && (src1 == exeDest);
    assign hit2_exe = twoSrc  && (src2 == exeDest);
    assign hit1_mem = useSrc1 && (src1 == memDest);
    assign hit2_mem = twoSrc  && (src2 == memDest);

    // With forwarding only a load in EXE cannot be bypassed in time.
    always_comb begin
        if (forwardEn) begin
            hazard = exeMemRen && exeWbEn && (hit1_exe || hit2_exe);
        end else begin
            hazard = (exeWbEn && (hit1_exe || hit2_exe)) ||
                     (memWbEn && (hit1_mem || hit2_mem));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fcnt_nx     = fcnt;
        freeze      = 1'b0;
        flush       = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = '0;
        case (state)
            // MEMWAIT behaves like RUN once memory is ready again.
            RUN, MEMWAIT: begin
                if (memBusy) begin
                    freeze   = 1'b1;
                    state_nx = MEMWAIT;
                end else if (exeBranch) begin
                    branchTaken = 1'b1;
                    branchAddr  = exeBranchAddr;
                    flush       = 1'b1;
                    if (FLUSH_EXTRA > 0) begin
                        state_nx = FLUSH;
                        fcnt_nx  = FLUSH_LOAD;
                    end else begin
                        state_nx = RUN;
                    end
                end else begin
                    freeze   = hazard;
                    state_nx = RUN;
                end
            end
            FLUSH: begin
                if (memBusy) begin
                    freeze = 1'b1;
                end else begin
                    flush = 1'b1;
                    if (fcnt <= 3'd1) begin
                        state_nx = RUN;
                        fcnt_nx  = '0;
                    end else begin
                        fcnt_nx = fcnt - 3'd1;
                    end
                end
            end
            default: begin
                state_nx = RUN;
                fcnt_nx  = '0;
            end
        endcase
        // Outputs are forced quiet while reset is asserted.
        if (!rst) begin
            freeze      = 1'b0;
            flush       = 1'b0;
            branchTaken = 1'b0;
            branchAddr  = '0;
        end
    end

    assign dbgState = state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .count (stallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branchTaken),
        .count (flushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_EXTRA=2: a rule-level model checked
// every negedge, plus literal expectations pinned at key points.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int REG_W = 4;
    localparam int FX    = 2;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             forwardEn = 0, useSrc1 = 0, twoSrc = 0;
    logic [REG_W-1:0] src1 = '0, src2 = '0, exeDest = '0, memDest = '0;
    logic             exeWbEn = 0, exeMemRen = 0, memWbEn = 0, memBusy = 0, exeBranch = 0;
    addr_t            exeBranchAddr = '0;
    logic             freeze, flush, branchTaken;
    addr_t            branchAddr;
    logic [CNT_W-1:0] stallCount, flushCount;
    state_t           dbgState;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Model state: remaining extra flush cycles and expected statistics.
    int               m_left = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic [CNT_W-1:0] stall_mark;

    hazard_ctrl #(.REG_W(REG_W), .FLUSH_EXTRA(FX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .useSrc1(useSrc1), .twoSrc(twoSrc),
        .src1(src1), .src2(src2), .exeDest(exeDest), .exeWbEn(exeWbEn), .exeMemRen(exeMemRen),
        .memDest(memDest), .memWbEn(memWbEn), .memBusy(memBusy), .exeBranch(exeBranch),
        .exeBranchAddr(exeBranchAddr), .freeze(freeze), .flush(flush),
        .branchTaken(branchTaken), .branchAddr(branchAddr), .stallCount(stallCount),
        .flushCount(flushCount), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        logic [REG_W-1:0] srcs [2];
        bit               used [2];
        bit               h;
        srcs[0] = src1; srcs[1] = src2;
        used[0] = useSrc1; used[1] = twoSrc;
        h = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (used[i]) begin
                if (forwardEn)
                    h |= exeMemRen && exeWbEn && (srcs[i] == exeDest);
                else
                    h |= (exeWbEn && (srcs[i] == exeDest)) || (memWbEn && (srcs[i] == memDest));
            end
        end
        return h;
    endfunction

    // Expected outputs, from the priority rules: memory wait, pending flush, branch, hazard.
    task automatic m_expect(output bit e_fr, output bit e_fl, output bit e_bt, output addr_t e_ba);
        e_fr = 0; e_fl = 0; e_bt = 0; e_ba = '0;
        if (!rst) return;
        if (memBusy) e_fr = 1;
        else if (m_left > 0) e_fl = 1;
        else if (exeBranch) begin
            e_bt = 1; e_fl = 1; e_ba = exeBranchAddr;
        end else e_fr = m_hazard();
    endtask

    always @(posedge clk or negedge rst) begin
        bit e_fr, e_fl, e_bt;
        addr_t e_ba;
        if (!rst) begin
            m_left = 0; m_stall = '0; m_flush = '0;
        end else begin
            m_expect(e_fr, e_fl, e_bt, e_ba);
            if (e_fr && m_stall != '1) m_stall = m_stall + 1;
            if (e_bt && m_flush != '1) m_flush = m_flush + 1;
            if (!memBusy) begin
                if (m_left > 0) m_left = m_left - 1;
                else if (exeBranch) m_left = FX;
            end
        end
    end

    always @(negedge clk) begin
        bit e_fr, e_fl, e_bt;
        addr_t e_ba;
        if (chk_on) begin
            m_expect(e_fr, e_fl, e_bt, e_ba);
            chk("m_freeze", 32'(freeze), 32'(e_fr));
            chk("m_flush", 32'(flush), 32'(e_fl));
            chk("m_branchTaken", 32'(branchTaken), 32'(e_bt));
            chk("m_branchAddr", branchAddr, e_ba);
            chk("m_stallCount", stallCount, m_stall);
            chk("m_flushCount", flushCount, m_flush);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic to_check();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        forwardEn = 0; useSrc1 = 0; twoSrc = 0; src1 = '0; src2 = '0;
        exeDest = '0; memDest = '0; exeWbEn = 0; exeMemRen = 0; memWbEn = 0;
        memBusy = 0; exeBranch = 0; exeBranchAddr = '0;
    endtask

    task automatic load_use();
        forwardEn = 1; exeMemRen = 1; exeWbEn = 1; exeDest = 4'd3; useSrc1 = 1; src1 = 4'd3;
    endtask

    initial begin
        chk_on = 1'b1;
        to_check();
        chk("rst_freeze", 32'(freeze), 0);
        chk("rst_stall", stallCount, 0);
        chk("rst_state", 32'(dbgState), 32'(RUN));
        #2 rst = 1'b1;

        // Load-use with forwarding.
        next_cycle(); load_use();
        to_check(); chk("lu_freeze", 32'(freeze), 1);
        next_cycle(); exeMemRen = 0;
        to_check(); chk("lu_noload_freeze", 32'(freeze), 0);
        chk("lu_stall", stallCount, 1);

        // No forwarding: MEM-stage match on src2, then EXE-stage match on src1.
        next_cycle(); clear_inputs();
        memWbEn = 1; memDest = 4'd5; twoSrc = 1; src2 = 4'd5;
        to_check(); chk("nf_mem_freeze", 32'(freeze), 1);
        next_cycle(); twoSrc = 0;
        to_check(); chk("nf_nosrc2_freeze", 32'(freeze), 0);
        next_cycle(); clear_inputs();
        exeWbEn = 1; exeDest = 4'd7; useSrc1 = 1; src1 = 4'd7;
        to_check(); chk("nf_exe_freeze", 32'(freeze), 1);

        // Branch over a load-use hazard, then two extra flush cycles.
        next_cycle(); clear_inputs(); load_use();
        exeBranch = 1; exeBranchAddr = 32'h40;
        to_check();
        chk("br_taken", 32'(branchTaken), 1);
        chk("br_addr", branchAddr, 32'h40);
        chk("br_flush", 32'(flush), 1);
        chk("br_freeze", 32'(freeze), 0);
        next_cycle(); exeBranch = 0; exeBranchAddr = 32'h0;
        to_check();
        chk("br_flushCount", flushCount, 1);
        chk("fx1_flush", 32'(flush), 1);
        chk("fx1_taken", 32'(branchTaken), 0);
        next_cycle(); to_check(); chk("fx2_flush", 32'(flush), 1);
        next_cycle(); to_check();
        chk("fx_end_flush", 32'(flush), 0);
        chk("fx_end_freeze", 32'(freeze), 1);

        // Memory wait holding a resolved branch for four cycles.
        next_cycle(); clear_inputs();
        stall_mark = m_stall;
        memBusy = 1; exeBranch = 1; exeBranchAddr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            to_check();
            chk("mw_freeze", 32'(freeze), 1);
            chk("mw_taken", 32'(branchTaken), 0);
            next_cycle();
        end
        memBusy = 0;
        to_check();
        chk("mw_stall_delta", stallCount - stall_mark, 4);
        chk("mw_release_taken", 32'(branchTaken), 1);
        chk("mw_release_flush", 32'(flush), 1);
        chk("mw_release_addr", branchAddr, 32'h80);

        // Memory wait inside FLUSH freezes and holds the remaining flush cycles.
        next_cycle(); exeBranch = 0; memBusy = 1;
        to_check();
        chk("fm_freeze", 32'(freeze), 1);
        chk("fm_flush", 32'(flush), 0);
        next_cycle(); memBusy = 0;
        to_check(); chk("fm_resume1", 32'(flush), 1);
        next_cycle(); to_check(); chk("fm_resume2", 32'(flush), 1);
        next_cycle(); to_check(); chk("fm_done", 32'(flush), 0);

        // Reset in the middle of FLUSH.
        next_cycle(); exeBranch = 1; exeBranchAddr = 32'h100;
        next_cycle(); exeBranch = 0;
        #1 rst = 1'b0;
        #1;
        chk("rf_flush", 32'(flush), 0);
        chk("rf_stall", stallCount, 0);
        chk("rf_flushCount", flushCount, 0);
        chk("rf_state", 32'(dbgState), 32'(RUN));
        #1 rst = 1'b1;
        to_check();
        chk("rf_after_flush", 32'(flush), 0);
        chk("rf_after_freeze", 32'(freeze), 0);

        // Reset in the middle of MEMWAIT.
        next_cycle(); memBusy = 1;
        next_cycle();
        #1 rst = 1'b0;
        #1;
        chk("rm_freeze", 32'(freeze), 0);
        chk("rm_stall", stallCount, 0);
        memBusy = 0;
        #1 rst = 1'b1;
        to_check();
        chk("rm_after_freeze", 32'(freeze), 0);
        chk("rm_after_state", 32'(dbgState), 32'(RUN));

        next_cycle();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline-control responder that drives the IF stage's freeze/branchTaken/branchAddr inputs and the IF/ID register's freeze/flush inputs.
- Detects load-use and data hazards from ID/EXE/MEM register info.
- Accepts resolved branches from EXE.
- Holds the front end during multi-cycle memory access.
- Keeps saturating stall and flush statistics.

Parameters:
REG_W, 4, register-address width (16 architectural registers)
FLUSH_EXTRA, 0, extra flush cycles after a taken branch, beyond the resolution cycle (0..7)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
forwardEn  in  1  forwarding unit enabled
useSrc1  in  1  ID instruction reads src1
twoSrc  in  1  ID instruction also reads src2
src1  in  REG_W  ID source register 1
src2  in  REG_W  ID source register 2
exeDest  in  REG_W  EXE-stage destination
exeWbEn  in  1  EXE-stage instruction writes back
exeMemRen  in  1  EXE-stage instruction is a load
memDest  in  REG_W  MEM-stage destination
memWbEn  in  1  MEM-stage instruction writes back
memBusy  in  1  data memory not ready; whole pipe must hold
exeBranch  in  1  EXE resolved a taken branch this cycle
exeBranchAddr  in  32  target of that branch
freeze  out  1  to IF stage and IF/ID register
flush  out  1  to IF/ID (and ID/EXE) register
branchTaken  out  1  to IF stage
branchAddr  out  32  to IF stage
stallCount  out  CNT_W  cycles with freeze=1
flushCount  out  CNT_W  taken-branch events

Behaviour:
- Reset (rst=0, async): state RUN, extra-flush counter 0, both stat counters 0.
- Reset outputs: freeze=0, flush=0, branchTaken=0, branchAddr=0.
- hazard (combinational):
  - forwardEn=1: hazard = exeMemRen & exeWbEn & ((useSrc1 & src1==exeDest) | (twoSrc & src2==exeDest)).
  - forwardEn=0: hazard = any enabled source matching exeDest with exeWbEn, or matching memDest with memWbEn.
- States: RUN, FLUSH, MEMWAIT.
- Priority within a cycle: memBusy > branch > hazard.
- RUN:
  - memBusy=1: freeze=1, flush=0, branchTaken=0; next state MEMWAIT. A pending exeBranch is held in EXE, not consumed.
  - Else exeBranch=1: branchTaken=1, branchAddr=exeBranchAddr, flush=1, freeze=0 (a hazard on the squashed ID instruction is ignored); flushCount++. Next state is FLUSH if FLUSH_EXTRA>0, loading the counter with FLUSH_EXTRA; otherwise next state is RUN.
  - Else freeze=hazard, flush=0, branchTaken=0.
- FLUSH: flush=1, freeze=0, branchTaken=0.
  - Counter decrements each cycle; return to RUN in the cycle it reaches 1.
  - memBusy in FLUSH: freeze=1 and flush=0; the counter holds.
- MEMWAIT: freeze=1, flush=0, branchTaken=0 while memBusy=1.
  - On memBusy=0, return to RUN that same cycle, with outputs evaluated as in RUN. A held exeBranch is therefore taken in the first non-busy cycle.
- branchAddr: equals exeBranchAddr whenever branchTaken=1; otherwise 0.
- Counters:
  - stallCount increments on every edge where freeze=1.
  - flushCount increments on every edge where branchTaken=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-FLUSH or mid-MEMWAIT: immediate return to reset values; no pending flush survives.
- Latency: hazard, branch and memBusy responses are combinational in the same cycle. Only FLUSH extension and the counters are registered.

Decomposition:
- Shared package hazard_pkg:
  - REG_W default.
  - State enum {RUN, FLUSH, MEMWAIT}.
  - Shared 32-bit address type with the IF stage.
- One sub-module, sat_counter (CNT_W, inc, async active-low rst), instantiated twice.

Test Plan:
1. Load-use, forwardEn=1: exeMemRen=1, exeWbEn=1, exeDest=3, useSrc1=1, src1=3 -> freeze=1 for that cycle, stallCount 0->1. With exeMemRen=0 -> freeze=0.
2. No-forward MEM hazard: forwardEn=0, memWbEn=1, memDest=5, twoSrc=1, src2=5, useSrc1=0 -> freeze=1. Same stimulus with twoSrc=0 -> freeze=0.
3. Branch with concurrent hazard: exeBranch=1, exeBranchAddr=32'h40, hazard present -> branchTaken=1, branchAddr=32'h40, flush=1, freeze=0, flushCount=1.
4. FLUSH_EXTRA=2: one exeBranch pulse -> flush high for exactly 3 consecutive cycles; branchTaken high only in the first.
5. memBusy 4 cycles with exeBranch=1 held -> freeze=1 and branchTaken=0 for 4 cycles, stallCount=4. Cycle 5 -> branchTaken=1, flush=1.
6. rst pulled low mid-FLUSH and mid-MEMWAIT -> all outputs and counters 0 immediately; after release, state RUN and freeze=0.
